// File: rtl/full_adder_bist.sv
// full_adder_bist: exhaustive 8-vector self-test for an external full adder
module full_adder_bist #(
    parameter int SETTLE_CYCLES = 1,
    parameter int LOOPS = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       a,
    output logic       b,
    output logic       cin,
    input  logic       out,
    input  logic       cout,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_count,
    output logic [2:0] first_fail_vec
);
    typedef enum logic [1:0] {IDLE, DRIVE, CHECK, DONE} state_t;
    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
    localparam logic [3:0] LAST_LOOP = 4'(LOOPS - 1);
    state_t state, state_nx;
    logic [2:0] v, v_nx, abc, ffv_nx;
    logic [3:0] loop_cnt, loop_nx, settle, settle_nx, err_nx;
    logic mismatch;
    assign {cin, b, a} = abc;
    assign busy = state == DRIVE || state == CHECK;
    assign done = state == DONE;
    assign pass = done && err_count == 4'd0;
    assign mismatch = (out != (a ^ b ^ cin)) || (cout != ((a & b) | (a & cin) | (b & cin)));
    always_comb begin
        state_nx = state;
        v_nx = v;
        loop_nx = loop_cnt;
        settle_nx = settle;
        err_nx = err_count;
        ffv_nx = first_fail_vec;
        case (state)
            IDLE, DONE: if (start) begin
                state_nx = DRIVE;
                v_nx = 3'd0;
                loop_nx = 4'd0;
                settle_nx = SETTLE_LOAD;
                err_nx = 4'd0;
                ffv_nx = 3'd0;
            end
            DRIVE: begin
                state_nx = settle == 4'd0 ? CHECK : DRIVE;
                settle_nx = settle == 4'd0 ? settle : settle - 4'd1;
            end
            CHECK: begin
                // err_count only leaves zero once an error is seen, so it marks the first failure
                if (mismatch) begin
                    err_nx = err_count == 4'd15 ? err_count : err_count + 4'd1;
                    ffv_nx = err_count == 4'd0 ? v : first_fail_vec;
                end
                settle_nx = SETTLE_LOAD;
                if (v != 3'd7) begin
                    state_nx = DRIVE;
                    v_nx = v + 3'd1;
                end else if (loop_cnt != LAST_LOOP) begin
                    state_nx = DRIVE;
                    v_nx = 3'd0;
                    loop_nx = loop_cnt + 4'd1;
                end else begin
                    state_nx = DONE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            v <= 3'd0;
            loop_cnt <= 4'd0;
            settle <= 4'd0;
            err_count <= 4'd0;
            first_fail_vec <= 3'd0;
            abc <= 3'd0;
        end else begin
            state <= state_nx;
            v <= v_nx;
            loop_cnt <= loop_nx;
            settle <= settle_nx;
            err_count <= err_nx;
            first_fail_vec <= ffv_nx;
            abc <= (state_nx == DRIVE || state_nx == CHECK) ? v_nx : 3'd0;
        end
    end
endmodule

// File: tb/tb_full_adder_bist.sv
// tb_full_adder_bist: three configurations driven against a fault-injectable adder model
module tb_full_adder_bist;
    localparam int SC[3] = '{1, 3, 2};
    localparam int LP[3] = '{1, 1, 4};
    typedef struct {
        int id;
        logic [3:0] err;
        logic [2:0] ffv;
        logic pass;
    } exp_t;
    logic clk, rst_n;
    logic [2:0] start, a, b, cin, out, cout, busy, done, pass;
    logic [3:0] err[3];
    logic [2:0] ffv[3];
    logic [7:0] mo[3], mc[3];
    exp_t q[$];
    int total = 0, bad = 0, cyc = 0;
    int t0[3];
    full_adder_bist #(.SETTLE_CYCLES(1), .LOOPS(1)) dut0 (.clk(clk), .rst_n(rst_n), .start(start[0]),
        .a(a[0]), .b(b[0]), .cin(cin[0]), .out(out[0]), .cout(cout[0]), .busy(busy[0]), .done(done[0]),
        .pass(pass[0]), .err_count(err[0]), .first_fail_vec(ffv[0]));
    full_adder_bist #(.SETTLE_CYCLES(3), .LOOPS(1)) dut1 (.clk(clk), .rst_n(rst_n), .start(start[1]),
        .a(a[1]), .b(b[1]), .cin(cin[1]), .out(out[1]), .cout(cout[1]), .busy(busy[1]), .done(done[1]),
        .pass(pass[1]), .err_count(err[1]), .first_fail_vec(ffv[1]));
    full_adder_bist #(.SETTLE_CYCLES(2), .LOOPS(4)) dut2 (.clk(clk), .rst_n(rst_n), .start(start[2]),
        .a(a[2]), .b(b[2]), .cin(cin[2]), .out(out[2]), .cout(cout[2]), .busy(busy[2]), .done(done[2]),
        .pass(pass[2]), .err_count(err[2]), .first_fail_vec(ffv[2]));
    always_comb begin
        for (int k = 0; k < 3; k++) begin
            out[k] = (a[k] ^ b[k] ^ cin[k]) ^ mo[k][{cin[k], b[k], a[k]}];
            cout[k] = (a[k] + b[k] + cin[k] >= 2) ^ mc[k][{cin[k], b[k], a[k]}];
        end
    end
    initial clk = 0;
    always #5 clk = ~clk;
    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, req, $time);
        end
    endtask
    function automatic exp_t model(input int k, input logic [7:0] m_o, input logic [7:0] m_c);
        exp_t e;
        logic [7:0] faulty = m_o | m_c;
        int n = $countones(faulty) * LP[k];
        e.id = k;
        e.err = 4'(n > 15 ? 15 : n);
        e.ffv = 3'd0;
        for (int i = 7; i >= 0; i--) if (faulty[i]) e.ffv = 3'(i);
        e.pass = n == 0;
        return e;
    endfunction
    initial begin
        logic [2:0] done_q = 3'd0, busy_q = 3'd0;
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            for (int k = 0; k < 3; k++) begin
                if (busy[k] && !busy_q[k]) t0[k] = cyc;
                if (busy[k]) chk($sformatf("vec%0d", k), {cin[k], b[k], a[k]}, ((cyc - t0[k]) / (SC[k] + 1)) % 8);
                else chk($sformatf("idle_vec%0d", k), {cin[k], b[k], a[k]}, 0);
                if (done[k] && !done_q[k]) begin
                    if (q.size() == 0) chk($sformatf("unexpected_done%0d", k), 1, 0);
                    else begin
                        e = q.pop_front();
                        chk("done_id", k, e.id);
                        chk($sformatf("err_count%0d", k), err[k], e.err);
                        chk($sformatf("first_fail%0d", k), ffv[k], e.ffv);
                        chk($sformatf("pass%0d", k), pass[k], e.pass);
                        chk($sformatf("latency%0d", k), cyc - t0[k], 8 * (SC[k] + 1) * LP[k]);
                    end
                end
            end
            done_q = done;
            busy_q = busy;
        end
    end
    task automatic outs_zero(input string name);
        for (int k = 0; k < 3; k++)
            chk($sformatf("%s%0d", name, k), {a[k], b[k], cin[k], busy[k], done[k], pass[k], err[k], ffv[k]}, 0);
    endtask
    task automatic wait_done(input int k, input bit noisy);
        int n = 0;
        while (!done[k] && n < 2000) begin
            start[k] = noisy && busy[k] && $urandom_range(0, 2) == 0;
            @(negedge clk);
            n++;
        end
        start[k] = 0;
        chk($sformatf("wait_done%0d", k), done[k], 1);
    endtask
    task automatic run(input int k, input logic [7:0] m_o, input logic [7:0] m_c, input bit noisy);
        mo[k] = m_o;
        mc[k] = m_c;
        q.push_back(model(k, m_o, m_c));
        start[k] = 1;
        @(negedge clk);
        start[k] = 0;
        wait_done(k, noisy);
    endtask
    initial begin
        int n;
        rst_n = 0;
        start = '0;
        for (int k = 0; k < 3; k++) begin
            mo[k] = '0;
            mc[k] = '0;
        end
        repeat (3) @(negedge clk);
        outs_zero("reset_out");
        rst_n = 1;
        @(negedge clk);
        run(0, 8'h00, 8'h00, 0);
        run(0, 8'h00, 8'hE8, 0);
        run(0, 8'hFF, 8'h00, 1);
        run(2, 8'hFF, 8'h00, 0);
        run(1, 8'h00, 8'h00, 1);
        run(2, 8'h00, 8'h00, 1);
        for (int i = 0; i < 10; i++)
            run($urandom_range(0, 2), $urandom_range(0, 1) ? 8'h00 : 8'($urandom),
                $urandom_range(0, 1) ? 8'h00 : 8'($urandom), 1);
        run(0, 8'h00, 8'hE8, 0);
        mc[0] = 8'h00;
        q.push_back(model(0, 8'h00, 8'h00));
        start[0] = 1;
        @(negedge clk);
        start[0] = 0;
        chk("restart_done", done[0], 0);
        chk("restart_busy", busy[0], 1);
        chk("restart_err", err[0], 0);
        chk("restart_ffv", ffv[0], 0);
        wait_done(0, 0);
        mo[0] = 8'hFF;
        start[0] = 1;
        @(negedge clk);
        start[0] = 0;
        n = 0;
        while ({cin[0], b[0], a[0]} != 3'd4 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("reach_v4", {cin[0], b[0], a[0]}, 4);
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
        outs_zero("midrun_reset");
        run(0, 8'h30, 8'h00, 0);
        run(0, 8'h00, 8'h00, 1);
        repeat (3) @(negedge clk);
        chk("queue_empty", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
